// File: rtl/serial_frame_tx.sv
// Serial framer: accepts a parallel word over valid/ready and shifts it out as
// start bit, data bits, optional even parity bit and stop bit on an idle-high line.
module serial_frame_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             tx_out,
  output logic             busy,
  output logic             frame_done,
  output logic [2:0]       state_dbg
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);

  // Handshake: a word transfers on the rising edge where data_valid && data_ready;
  // data_ready is high only in IDLE, and the word is captured on that same edge.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]   cap_q, cap_d;
  logic               tx_q, tx_d;
  logic               frame_done_q, frame_done_d;
  logic               last_div;
  logic [BIT_W-1:0]   sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      cap_q        <= '0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      cap_q        <= cap_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    cap_d        = cap_q;
    frame_done_d = 1'b0;
    tx_d         = 1'b1;
    sel          = '0;
    last_div     = (div_q == DIV_W'(CLKS_PER_BIT - 1));

    case (state_q)
      IDLE: begin
        if (data_valid) begin
          state_d = START;
          cap_d   = data_in;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (last_div) begin
          state_d = DATA;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DATA: begin
        if (last_div) begin
          div_d = '0;
          if (bit_q == BIT_W'(WIDTH - 1)) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      PARITY: begin
        if (last_div) begin
          state_d = STOP;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      STOP: begin
        if (last_div) begin
          state_d      = IDLE;
          div_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
        bit_d   = '0;
      end
    endcase

    // The line level is registered, so it is derived from where the FSM goes next.
    sel = (MSB_FIRST != 0) ? (BIT_W'(WIDTH - 1) - bit_d) : bit_d;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cap_d[sel];
      PARITY:  tx_d = ^cap_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign data_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign tx_out     = tx_q;
  assign frame_done = frame_done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three instances (default, MSB-first without parity,
// one clock per bit) checked cycle by cycle against a queue of expected line states.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] din [3];
  logic       vld [3];
  logic       rdy [3];
  logic       tx_w [3];
  logic       bsy [3];
  logic       fd [3];
  logic [2:0] st [3];

  // Expected entry per cycle: {tx_out, busy, frame_done, data_ready}
  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_frame_tx u_dut (
    .clk(clk), .reset(reset), .data_in(din[0]), .data_valid(vld[0]), .data_ready(rdy[0]),
    .tx_out(tx_w[0]), .busy(bsy[0]), .frame_done(fd[0]), .state_dbg(st[0])
  );

  serial_frame_tx #(.WIDTH(4), .CLKS_PER_BIT(4), .PARITY_EN(0), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .data_in(din[1]), .data_valid(vld[1]), .data_ready(rdy[1]),
    .tx_out(tx_w[1]), .busy(bsy[1]), .frame_done(fd[1]), .state_dbg(st[1])
  );

  serial_frame_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(1), .MSB_FIRST(0)) u_fast (
    .clk(clk), .reset(reset), .data_in(din[2]), .data_valid(vld[2]), .data_ready(rdy[2]),
    .tx_out(tx_w[2]), .busy(bsy[2]), .frame_done(fd[2]), .state_dbg(st[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] obs(input int idx);
    return {tx_w[idx], bsy[idx], fd[idx], rdy[idx]};
  endfunction

  // Builds the expected line for one frame from the instance configuration.
  task automatic push_frame(input int idx, input logic [3:0] w);
    int cpb;
    bit msb, par;
    logic bits[$];
    cpb = (idx == 2) ? 1 : 4;
    msb = (idx == 1);
    par = (idx != 1);
    bits.push_back(1'b0);
    for (int i = 0; i < 4; i++) bits.push_back(msb ? w[3-i] : w[i]);
    if (par) bits.push_back(^w);
    bits.push_back(1'b1);
    foreach (bits[k]) repeat (cpb) exp_q.push_back({bits[k], 1'b1, 1'b0, 1'b0});
    exp_q.push_back(4'b1011);
  endtask

  // Called at a negedge; pops and compares one entry per cycle.
  task automatic drain(input int idx, input bit noise, input int limit);
    int n = 0;
    logic [3:0] e;
    while (exp_q.size() > 0 && n < limit) begin
      e = exp_q.pop_front();
      check($sformatf("line%0d", idx), 32'(obs(idx)), 32'(e));
      if (noise) begin
        din[idx] = 4'($urandom_range(0, 15));
        vld[idx] = (exp_q.size() > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic start(input int idx, input logic [3:0] w, input bit keep);
    din[idx] = w;
    vld[idx] = 1'b1;
    check("ready_before_accept", 32'(rdy[idx]), 32'd1);
    push_frame(idx, w);
    @(negedge clk);
    if (!keep) vld[idx] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      din[i] = '0;
      vld[i] = 1'b0;
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_idle", 32'(obs(i)), 32'b1001);
      check("reset_state", 32'(st[i]), 32'd0);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_valid", 32'(obs(0)), 32'b1001);

    // Default config, 1011 LSB first with parity
    start(0, 4'b1011, 0);
    drain(0, 0, 1000);

    // MSB first, no parity
    start(1, 4'b1011, 0);
    drain(1, 0, 1000);

    // One clock per bit
    start(2, 4'hF, 0);
    drain(2, 0, 1000);

    // Valid held high: second word accepted in the frame_done cycle
    start(0, 4'hA, 1);
    din[0] = 4'h5;
    drain(0, 0, 1000);
    vld[0] = 1'b0;
    push_frame(0, 4'h5);
    drain(0, 0, 1000);
    check("after_back_to_back", 32'(obs(0)), 32'b1001);

    // Reset in the middle of the data bits abandons the frame
    start(0, 4'h6, 0);
    drain(0, 0, 8);
    #2 reset = 1'b0;
    #1 check("async_reset", 32'(obs(0)), 32'b1001);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("no_done_after_reset", 32'(obs(0)), 32'b1001);
    end
    reset = 1'b1;
    @(negedge clk);
    start(0, 4'h9, 0);
    drain(0, 0, 1000);

    // Input noise and valid while busy must not disturb the frame
    start(0, 4'h3, 0);
    drain(0, 1, 1000);
    check("no_second_capture", 32'(obs(0)), 32'b1001);

    // Random words on every instance
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 3; i++) begin
        start(i, 4'($urandom_range(0, 15)), 0);
        drain(i, (r % 2) == 1, 1000);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
